// File: rtl/ram_delay_pkg.sv
// Shared types and constants for the ram_delay sequencing controller.
package ram_delay_pkg;

    // Controller phases: drain/restart, initial fill, steady-state delay.
    typedef enum logic [1:0] {
        RECONF = 2'd0,
        FILL   = 2'd1,
        RUN    = 2'd2
    } state_t;

    // Shortest delay the RAM addressing scheme supports.
    localparam int unsigned N_MIN = 2;

    // Default address width and the longest delay it can express.
    localparam int unsigned NBITS_ADDR_DFLT = 9;
    localparam int unsigned N_MAX           = (1 << NBITS_ADDR_DFLT) - 1;

    // Longest legal delay for an arbitrary address width.
    function automatic int unsigned n_max(input int unsigned nbits);
        return (1 << nbits) - 1;
    endfunction

endpackage

// File: rtl/ram_delay_prime_pipe.sv
// Valid shift register that tracks which RAM writes produce fully delayed
// outputs, aligned to the RAM read latency. Synchronous clear on restart.
module ram_delay_prime_pipe #(
    parameter int P_DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [P_DEPTH-1:0] sr;

    // Shift one stage per cycle; reset or restart empties every stage.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every stage
        // samples the value from before this edge, giving a true shift.
        if (!rst || clr) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < P_DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[P_DEPTH-1];

endmodule

// File: rtl/ram_delay_ctrl.sv
// Sequencing controller for a single ram_delay instance: drives the write
// strobe and circular address, handles delay-length changes and flushes,
// and qualifies the RAM outputs once they hold truly n-delayed samples.
module ram_delay_ctrl
    import ram_delay_pkg::*;
#(
    parameter int P_NBITS_DATA = 14,
    parameter int P_NBITS_ADDR = 9,
    parameter int P_RAM_LAT    = 1,
    parameter int P_N_RST      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    input  logic [P_NBITS_DATA-1:0] s_data,
    output logic                    s_ready,
    input  logic                    cfg_wr,
    input  logic [P_NBITS_ADDR-1:0] cfg_n,
    output logic                    cfg_ack,
    output logic                    cfg_err,
    input  logic                    flush,
    output logic                    ram_wr,
    output logic [P_NBITS_DATA-1:0] ram_d,
    output logic                    ram_addr_en,
    output logic [P_NBITS_ADDR-1:0] ram_addr,
    output logic [P_NBITS_ADDR-1:0] ram_n,
    input  logic [P_NBITS_DATA-1:0] ram_qn,
    input  logic [P_NBITS_DATA-1:0] ram_qo,
    output logic                    m_valid,
    output logic [P_NBITS_DATA-1:0] m_qn,
    output logic [P_NBITS_DATA-1:0] m_qo,
    output logic [P_NBITS_ADDR-1:0] fill,
    output logic                    busy
);

    localparam int LAT_W = $clog2(P_RAM_LAT + 1);
    localparam logic [LAT_W-1:0]        LAT_INIT = LAT_W'(P_RAM_LAT);
    localparam logic [P_NBITS_ADDR-1:0] N_RST    = P_NBITS_ADDR'(P_N_RST);
    localparam logic [P_NBITS_ADDR-1:0] N_LEGAL  = P_NBITS_ADDR'(N_MIN);

    state_t                  state,   state_nxt;
    logic [P_NBITS_ADDR-1:0] n_act,   n_nxt;
    logic [P_NBITS_ADDR-1:0] addr,    addr_nxt;
    logic [P_NBITS_ADDR-1:0] fill_q,  fill_nxt;
    logic [LAT_W-1:0]        lat_cnt, lat_nxt;
    logic                    ack_nxt, err_nxt;
    logic                    restart;
    logic                    wr;
    logic                    prime_in;

    // Sample acceptance and RAM-facing passthroughs.
    assign s_ready     = (state != RECONF) && !cfg_wr && !flush;
    assign wr          = s_valid && s_ready;
    assign ram_wr      = wr;
    assign ram_d       = s_data;
    assign ram_addr_en = 1'b1;
    assign ram_addr    = addr;
    assign ram_n       = n_act;
    assign m_qn        = ram_qn;
    assign m_qo        = ram_qo;
    assign fill        = fill_q;
    assign busy        = (state == RECONF);

    // Only writes in RUN read back a location written n samples earlier.
    assign prime_in    = wr && (state == RUN);

    // Next-state, configuration and address sequencing.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        n_nxt     = n_act;
        addr_nxt  = addr;
        fill_nxt  = fill_q;
        lat_nxt   = lat_cnt;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        restart   = 1'b0;

        // A legal cfg_wr also covers a simultaneous flush.
        if (cfg_wr) begin
            if (cfg_n >= N_LEGAL) begin
                n_nxt   = cfg_n;
                ack_nxt = 1'b1;
                restart = 1'b1;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (flush) begin
            restart = 1'b1;
        end

        if (restart) begin
            state_nxt = RECONF;
            lat_nxt   = LAT_INIT;
            addr_nxt  = '0;
            fill_nxt  = '0;
        end else begin
            case (state)
                RECONF: begin
                    // Hold off writes long enough for in-flight reads to drain.
                    if (lat_cnt == '0) begin
                        state_nxt = FILL;
                        addr_nxt  = '0;
                        fill_nxt  = '0;
                    end else begin
                        lat_nxt = lat_cnt - 1'b1;
                    end
                end
                FILL, RUN: begin
                    if (wr) begin
                        addr_nxt = (addr == n_act - 1'b1) ? '0 : addr + 1'b1;
                        if (fill_q != n_act) begin
                            fill_nxt = fill_q + 1'b1;
                        end
                        if (state == FILL && (fill_q + 1'b1) == n_act) begin
                            state_nxt = RUN;
                        end
                    end
                end
                default: state_nxt = RECONF;
            endcase
        end
    end

    // Controller state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= RECONF;
            n_act   <= N_RST;
            addr    <= '0;
            fill_q  <= '0;
            lat_cnt <= LAT_INIT;
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            n_act   <= n_nxt;
            addr    <= addr_nxt;
            fill_q  <= fill_nxt;
            lat_cnt <= lat_nxt;
            cfg_ack <= ack_nxt;
            cfg_err <= err_nxt;
        end
    end

    ram_delay_prime_pipe #(
        .P_DEPTH (P_RAM_LAT)
    ) u_prime_pipe (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .din  (prime_in),
        .dout (m_valid)
    );

endmodule

// File: tb/tb_ram_delay_ctrl.sv
// Self-checking bench for ram_delay_ctrl with a behavioural ram_delay model
// and a scoreboard of expected delayed/current sample pairs.
module tb_ram_delay_ctrl;

    localparam int DW   = 14;
    localparam int AW   = 9;
    localparam int LAT  = 1;
    localparam int NRST = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          cfg_wr;
    logic [AW-1:0] cfg_n;
    logic          cfg_ack;
    logic          cfg_err;
    logic          flush;
    logic          ram_wr;
    logic [DW-1:0] ram_d;
    logic          ram_addr_en;
    logic [AW-1:0] ram_addr;
    logic [AW-1:0] ram_n;
    logic [DW-1:0] ram_qn;
    logic [DW-1:0] ram_qo;
    logic          m_valid;
    logic [DW-1:0] m_qn;
    logic [DW-1:0] m_qo;
    logic [AW-1:0] fill;
    logic          busy;

    ram_delay_ctrl #(
        .P_NBITS_DATA (DW),
        .P_NBITS_ADDR (AW),
        .P_RAM_LAT    (LAT),
        .P_N_RST      (NRST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .cfg_wr      (cfg_wr),
        .cfg_n       (cfg_n),
        .cfg_ack     (cfg_ack),
        .cfg_err     (cfg_err),
        .flush       (flush),
        .ram_wr      (ram_wr),
        .ram_d       (ram_d),
        .ram_addr_en (ram_addr_en),
        .ram_addr    (ram_addr),
        .ram_n       (ram_n),
        .ram_qn      (ram_qn),
        .ram_qo      (ram_qo),
        .m_valid     (m_valid),
        .m_qn        (m_qn),
        .m_qo        (m_qo),
        .fill        (fill),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ram_delay: read-before-write at addr, LAT-cycle output pipe.
    logic [DW-1:0] mem   [0:(1<<AW)-1];
    logic [DW-1:0] qn_sr [LAT];
    logic [DW-1:0] qo_sr [LAT];

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        for (int i = 0; i < LAT; i++) begin
            qn_sr[i] = '0;
            qo_sr[i] = '0;
        end
    end

    always @(posedge clk) begin
        qn_sr[0] <= mem[ram_addr];
        qo_sr[0] <= ram_d;
        for (int i = 1; i < LAT; i++) begin
            qn_sr[i] <= qn_sr[i-1];
            qo_sr[i] <= qo_sr[i-1];
        end
        if (ram_wr && ram_addr_en) mem[ram_addr] <= ram_d;
    end

    assign ram_qn = qn_sr[LAT-1];
    assign ram_qo = qo_sr[LAT-1];

    // Counters and reference model state.
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int qn;
        int qo;
    } sb_t;
    sb_t sb_q[$];

    int mdl_n    = NRST;
    int mdl_addr = 0;
    int mdl_cnt  = 0;
    int d        = 0;
    int mv_cnt   = 0;
    int first_mv_cyc = -1;
    int prime_cyc    = -1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard pop on every qualified output.
    always @(negedge clk) begin
        if (rst && m_valid) begin
            sb_t e;
            mv_cnt++;
            if (first_mv_cyc < 0) first_mv_cyc = cyc;
            chk("sb_has_entry", int'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("m_qn", int'(m_qn), e.qn);
                chk("m_qo", int'(m_qo), e.qo);
                chk("qo_minus_qn", int'(m_qo) - int'(m_qn), mdl_n);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_fill();
        return (mdl_cnt < mdl_n) ? mdl_cnt : mdl_n;
    endfunction

    // One accepted sample; checks strobe/address and post-edge fill level.
    task automatic do_write();
        sb_t e;
        s_valid = 1'b1;
        s_data  = DW'(d);
        #1;
        chk("s_ready_wr", int'(s_ready), 1);
        chk("ram_wr", int'(ram_wr), 1);
        chk("ram_addr", int'(ram_addr), mdl_addr);
        if (mdl_cnt >= mdl_n) begin
            e.qn = d - mdl_n;
            e.qo = d;
            sb_q.push_back(e);
            if (mdl_cnt == mdl_n) prime_cyc = cyc;
        end
        mdl_cnt++;
        mdl_addr = (mdl_addr == mdl_n - 1) ? 0 : mdl_addr + 1;
        d++;
        step();
        s_valid = 1'b0;
        chk("fill", int'(fill), exp_fill());
    endtask

    // Issue cfg_wr and/or flush for one cycle and follow the RECONF window.
    task automatic request(input logic c, input int nn, input logic f);
        logic legal;
        legal   = f || (c && nn >= 2);
        cfg_wr  = c;
        cfg_n   = AW'(nn);
        flush   = f;
        s_valid = 1'b1;
        #1;
        chk("s_ready_req", int'(s_ready), 0);
        chk("ram_wr_req", int'(ram_wr), 0);
        step();
        cfg_wr  = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        chk("cfg_ack", int'(cfg_ack), int'(c && nn >= 2));
        chk("cfg_err", int'(cfg_err), int'(c && nn < 2));
        if (legal) begin
            if (c) mdl_n = nn;
            mdl_addr = 0;
            mdl_cnt  = 0;
            for (int i = 0; i <= LAT; i++) begin
                chk("busy_reconf", int'(busy), 1);
                chk("s_ready_reconf", int'(s_ready), 0);
                if (i > 0) chk("cfg_ack_pulse", int'(cfg_ack), 0);
                step();
            end
        end
        chk("busy_done", int'(busy), 0);
        chk("ram_n", int'(ram_n), mdl_n);
        chk("fill_after_req", int'(fill), exp_fill());
    endtask

    task automatic check_reset_state();
        chk("rst_busy", int'(busy), 1);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_fill", int'(fill), 0);
        chk("rst_ram_n", int'(ram_n), NRST);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_addr_en", int'(ram_addr_en), 1);
        chk("rst_cfg_ack", int'(cfg_ack), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_ram_wr", int'(ram_wr), 0);
    endtask

    task automatic release_reset();
        rst = 1'b1;
        mdl_n = NRST;
        mdl_addr = 0;
        mdl_cnt = 0;
        repeat (LAT) step();
        chk("busy_pre_fill", int'(busy), 1);
        step();
        chk("busy_fill", int'(busy), 0);
        chk("s_ready_fill", int'(s_ready), 1);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) step();
    endtask

    initial begin
        int base;
        rst = 1'b0; s_valid = 1'b0; s_data = '0;
        cfg_wr = 1'b0; cfg_n = '0; flush = 1'b0;
        step();
        step();
        check_reset_state();
        release_reset();

        // Back-to-back fill and run with n=16.
        first_mv_cyc = -1;
        for (int i = 0; i < 40; i++) do_write();
        idle(LAT + 2);
        chk("first_mv_latency", first_mv_cyc - prime_cyc, LAT);
        chk("sb_drained_1", sb_q.size(), 0);

        // Gapped writes after a flush.
        request(1'b0, 0, 1'b1);
        base = mv_cnt;
        for (int i = 0; i < 20; i++) begin
            do_write();
            step();
        end
        idle(LAT + 2);
        chk("gapped_mv_count", mv_cnt - base, 4);

        // Shrink to n=5 during RUN.
        request(1'b1, 5, 1'b0);
        first_mv_cyc = -1;
        for (int i = 0; i < 12; i++) do_write();
        idle(LAT + 2);
        chk("first_mv_latency_n5", first_mv_cyc - prime_cyc, LAT);

        // Illegal lengths leave n and the stream alone.
        request(1'b1, 1, 1'b0);
        for (int i = 0; i < 3; i++) do_write();
        request(1'b1, 0, 1'b0);
        for (int i = 0; i < 3; i++) do_write();
        idle(LAT + 2);

        // Simultaneous cfg_wr and flush, then a plain flush.
        request(1'b1, 8, 1'b1);
        for (int i = 0; i < 12; i++) do_write();
        idle(LAT + 2);
        request(1'b0, 0, 1'b1);
        for (int i = 0; i < 10; i++) do_write();
        idle(LAT + 2);

        // Reset pulse mid-RUN, then refill as after power-up.
        rst = 1'b0;
        step();
        check_reset_state();
        release_reset();
        first_mv_cyc = -1;
        for (int i = 0; i < 20; i++) do_write();
        idle(LAT + 2);
        chk("first_mv_latency_rst", first_mv_cyc - prime_cyc, LAT);
        chk("sb_drained_end", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
